// File: rtl/uart_rx_core.sv
// ============================================================================
// Module   : uart_rx_core
// Purpose  : Oversampling UART receiver. The serial line is synchronised,
//            majority-voted over three samples and framed by a bit-period
//            counter. Good frames are delivered on rx_data with a one-cycle
//            rx_status pulse. Bad stop bits raise frame_err and park the FSM
//            in BREAK until the line returns high.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   OVERSAMPLE : clk16 cycles per bit period (default 16)
//   DATA_BITS  : data bits per frame, LSB first (default 8)
// Ports
//   clk16      in   16x baud oversample clock, rising edge
//   reset      in   asynchronous, active-low reset
//   uart_rx    in   asynchronous serial line, idle high
//   rx_data    out  last correctly framed word, held until the next good frame
//   rx_status  out  one-cycle pulse per good frame
//   frame_err  out  stop bit sampled low on the last completed frame
//   parity_err out  even-parity mismatch on the last completed frame
//   busy       out  high whenever the FSM is not in IDLE
// Build option
//   UART_RX_PARITY_EN : when defined, an even-parity bit follows the data
//                       bits. When undefined the format is 8N1 and
//                       parity_err is tied to 0.
// ============================================================================
`default_nettype none

module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk16,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Last count of a bit period, and the count that lands mid start bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e                 state_q,      state_d;
  logic [CNT_W-1:0]       cnt_q,        cnt_d;
  logic [IDX_W-1:0]       idx_q,        idx_d;
  logic [DATA_BITS-1:0]   data_q,       data_d;
  logic [DATA_BITS-1:0]   rx_data_q,    rx_data_d;
  logic                   rx_status_q,  rx_status_d;
  logic                   frame_err_q,  frame_err_d;
  logic [1:0]             sync_q;
  logic [2:0]             vote_q;
  logic                   voted_prev_q;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit_q, parity_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // Majority of the three most recent synchronised samples; a single-cycle
  // glitch on the line cannot flip this.
  logic voted;
  assign voted = (vote_q[0] & vote_q[1]) |
                 (vote_q[0] & vote_q[2]) |
                 (vote_q[1] & vote_q[2]);

  // Incoming sample joined onto the data word; the upper DATA_BITS bits are
  // the word shifted right by one with the new bit at the MSB, so after
  // DATA_BITS samples the first-received bit sits at the LSB.
  logic [DATA_BITS:0] data_ext;
  assign data_ext = {voted, data_q};

  // --------------------------------------------------------------------------
  // Input synchroniser and vote shift register. Reset to the idle level so
  // that a line already low at release is seen as a fresh falling edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk16 or negedge reset) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      vote_q       <= 3'b111;
      voted_prev_q <= 1'b1;
    end else begin
      sync_q       <= {sync_q[0], uart_rx};
      vote_q       <= {vote_q[1:0], sync_q[1]};
      voted_prev_q <= voted;
    end
  end

  // --------------------------------------------------------------------------
  // FSM and datapath state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk16 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      rx_data_q    <= '0;
      rx_status_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      rx_data_q    <= rx_data_d;
      rx_status_q  <= rx_status_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    rx_data_d    = rx_data_q;
    rx_status_d  = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (voted_prev_q && !voted) begin
          state_d = START;
        end
      end

      // Re-check the line half a bit in; a high line here was a glitch.
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = voted ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // From mid start bit, a full period lands every sample mid bit.
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          data_d = data_ext[DATA_BITS:1];
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          parity_bit_d = voted;
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      // Error flags are refreshed on every stop sample, good or bad. Data is
      // delivered on a good stop bit even when parity is wrong.
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = ^{data_q, parity_bit_q};
`endif
          if (voted) begin
            rx_data_d   = data_q;
            frame_err_d = 1'b0;
            rx_status_d = 1'b1;
            state_d     = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Line held low past the frame: wait for idle before hunting for a
      // start edge again.
      BREAK: begin
        cnt_d = '0;
        idx_d = '0;
        if (voted) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rx_data   = rx_data_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Self-checking bench for uart_rx_core. A vector table drives
//            whole frames and checks the settled outputs; a scoreboard
//            queue predicts every rx_status pulse (data, cycle, flags).
//            Hand-written sequences cover glitch reject, back-to-back
//            frames, reset mid-frame and (with UART_RX_PARITY_EN) parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
  localparam int STOP_OFS = 168;
`else
  localparam bit PAR_EN   = 1'b0;
  localparam int STOP_OFS = 152;
`endif
  localparam int NV = 6;

  logic       clk16;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_core #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk16      (clk16),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_status  (rx_status),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  // Count of rising edges; read on falling edges.
  int cyc = 0;
  always @(posedge clk16) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic p);
    logic x;
    x = ^{d, p};
    return PAR_EN & x;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard: one entry per expected rx_status pulse.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         cyc;
  } sb_t;

  sb_t exp_q[$];
  sb_t mon_e;

  always @(negedge clk16) begin
    if (reset && rx_status) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(rx_status), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_data",  32'(rx_data),    32'(mon_e.data));
        chk("pulse_cycle", 32'(cyc),        32'(mon_e.cyc));
        chk("pulse_ferr",  32'(frame_err),  32'd0);
        chk("pulse_perr",  32'(parity_err), 32'(mon_e.perr));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line drivers (called on a falling edge, return on a falling edge).
  // --------------------------------------------------------------------------
  task automatic drive_level(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk16);
  endtask

  // Leaves the line at the stop level; the caller decides when to idle it.
  // The voted line falls four edges after the start bit is driven, and the
  // pulse follows the stop-bit sample by one cycle.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stop_lvl, input int stop_cycles);
    sb_t e;
    if (stop_lvl) begin
      e.data = d;
      e.perr = exp_perr(d, p);
      e.cyc  = cyc + 4 + STOP_OFS + 1;
      exp_q.push_back(e);
    end
    drive_level(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_level(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive_level(p, 16);
`endif
    drive_level(stop_lvl, stop_cycles);
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_lvl;
    int         stop_cycles;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 16,  8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 640, 8'hA5, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 16,  8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 16,  8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 16,  8'hFF, 1'b0};
    vecs[5] = '{8'h6E, 1'b1, 1'b1, 16,  8'h6E, 1'b0};

    reset   = 1'b0;
    uart_rx = 1'b1;
    #1;
    chk("rst_rx_data",    32'(rx_data),    32'h00);
    chk("rst_rx_status",  32'(rx_status),  32'd0);
    chk("rst_frame_err",  32'(frame_err),  32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    repeat (3) @(negedge clk16);
    reset = 1'b1;
    repeat (10) @(negedge clk16);
    chk("idle_busy", 32'(busy), 32'd0);

    // ---- table-driven frames ----
    for (int k = 0; k < NV; k++) begin
      send_frame(vecs[k].data, vecs[k].par_bit, vecs[k].stop_lvl, vecs[k].stop_cycles);
      if (!vecs[k].stop_lvl) begin
        chk("break_busy",    32'(busy),      32'd1);
        chk("break_ferr",    32'(frame_err), 32'd1);
        chk("break_rx_data", 32'(rx_data),   32'(vecs[k].exp_data));
      end
      uart_rx = 1'b1;
      repeat (12) @(negedge clk16);
      chk("vec_rx_data", 32'(rx_data),    32'(vecs[k].exp_data));
      chk("vec_ferr",    32'(frame_err),  32'(vecs[k].exp_ferr));
      chk("vec_perr",    32'(parity_err), 32'(exp_perr(vecs[k].data, vecs[k].par_bit)));
      chk("vec_busy",    32'(busy),       32'd0);
    end

    // ---- glitch: four low cycles must be rejected at mid start bit ----
    drive_level(1'b0, 4);
    drive_level(1'b1, 2);
    chk("glitch_busy_start", 32'(busy), 32'd1);
    drive_level(1'b1, 20);
    chk("glitch_busy_end", 32'(busy),    32'd0);
    chk("glitch_rx_data",  32'(rx_data), 32'h6E);

    // ---- back-to-back: next start falls the cycle after STOP -> IDLE ----
    send_frame(8'h55, 1'b0, 1'b1, 9);
    send_frame(8'hC3, 1'b0, 1'b1, 16);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk16);
    chk("b2b_rx_data", 32'(rx_data), 32'hC3);

    // ---- reset mid-frame: 0x5A aborted during data bit 4 ----
    drive_level(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_level(((8'h5A >> i) & 8'h01) != 8'h00, 16);
    drive_level(1'b1, 8);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_rx_data",    32'(rx_data),    32'h00);
    chk("abort_rx_status",  32'(rx_status),  32'd0);
    chk("abort_frame_err",  32'(frame_err),  32'd0);
    chk("abort_parity_err", 32'(parity_err), 32'd0);
    chk("abort_busy",       32'(busy),       32'd0);
    repeat (4) @(negedge clk16);
    reset = 1'b1;
    drive_level(1'b1, 200);
    chk("post_abort_rx_data", 32'(rx_data), 32'h00);
    chk("post_abort_busy",    32'(busy),    32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 16);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk16);
    chk("after_abort_rx_data", 32'(rx_data),   32'h81);
    chk("after_abort_ferr",    32'(frame_err), 32'd0);

`ifdef UART_RX_PARITY_EN
    // ---- parity: good then bad parity bit on 0x07 ----
    send_frame(8'h07, 1'b1, 1'b1, 16);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk16);
    chk("par_good_perr", 32'(parity_err), 32'd0);
    send_frame(8'h07, 1'b0, 1'b1, 16);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk16);
    chk("par_bad_perr",    32'(parity_err), 32'd1);
    chk("par_bad_rx_data", 32'(rx_data),    32'h07);
`endif

    // ---- drain scoreboard with a bounded wait ----
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk16);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
